pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
- Central sequencer for the 5-stage pipeline register set (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Each cycle, produces the per-stage enables, flushes and PC enable from the inputs below:
  - instruction/data cache handshakes (ihit/dhit)
  - load-use hazard detection
  - branch/jump redirect resolved in MEM
  - halt in MEM
- Owns the halt drain FSM and saturating stall/flush performance counters.
- Sits beside the pipeline register interface in the datapath top level.

Parameters:
CNT_W, 32, width of stall_count and flush_count (saturating)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous active-high reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dmemren_mem  in  1  load in MEM stage
dmemwen_mem  in  1  store in MEM stage
memren_ex  in  1  load in EX stage
rt_ex  in  5  destination of load in EX
rs_id  in  5  rs of instruction in ID
rt_id  in  5  rt of instruction in ID
uses_rt_id  in  1  ID instruction reads rt as a source
redirect_mem  in  1  taken branch or jump resolved in MEM
halt_mem  in  1  halt instruction in MEM
pc_en  out  1  PC register load enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables
flush_ifid, flush_idex, flush_exmem  out  1 each  load bubble into that register (valid only with its enable)
halted  out  1  processor halted (sticky)
stall_count  out  CNT_W  cycles in RUN with pc_en=0
flush_count  out  CNT_W  redirect events

Behaviour:
- Clock and reset: single clock CLK, synchronous active-high reset RST.
- FSM states: RUN, DRAIN, HALTED.
- Reset: state=RUN, halted=0, counters=0. Reset asserted mid-stall or mid-drain overrides everything on the next edge.
- Output timing: enables and flushes are combinational from state and inputs (zero latency). Counters and state are registered.
- RUN priority, highest first:
  1. dstall = (dmemren_mem|dmemwen_mem)&!dhit: all four enables=0, all flushes=0, pc_en=0. Holds the entire pipe; the MEM access is retried.
  2. redirect_mem: all enables=1; flush_ifid=flush_idex=flush_exmem=1; pc_en=1 (PC loads target). A redirect coincident with a load-use hazard or !ihit wins.
  3. lu = memren_ex & rt_ex!=0 & (rt_ex==rs_id | (uses_rt_id & rt_ex==rt_id)):
     - pc_en=0, ifid_en=0
     - idex_en=1 with flush_idex=1
     - exmem_en=memwb_en=1
  4. !ihit: pc_en=0; ifid_en=1 with flush_ifid=1; other enables=1.
  5. otherwise: all enables=1, no flushes, pc_en=1.
- Halt:
  - halt_mem & !dstall in RUN: apply the rule-5 enables except pc_en=0 and flush_ifid=flush_idex=flush_exmem=1 (younger instructions killed). Next state DRAIN.
  - redirect_mem and halt_mem together are illegal: halt takes precedence, and the assertion flags it.
- DRAIN (exactly one cycle): memwb_en=1 (halt reaches WB); all other enables=0, pc_en=0. Next state HALTED.
- HALTED: all enables=0, flushes=0, pc_en=0, halted=1. Held until RST.
- Counters:
  - stall_count += 1 each RUN cycle with pc_en=0.
  - flush_count += 1 each RUN cycle with redirect_mem & !dstall.
  - Both saturate at all-ones and do not wrap.
  - Both are frozen in DRAIN/HALTED.

Decomposition:
- Shared cpu_types_pkg additions:
  - ctrl_state_t enum {RUN, DRAIN, HALTED}
  - regbits_t (5-bit register index), if not already present
- Sub-module hazard_unit (combinational lu detection) is natural; instantiate once.
- Counters are inline.

Test Plan:
- Load r5 in EX (memren_ex=1, rt_ex=5), ID reads rs_id=5, ihit=dhit=1 -> pc_en=0, ifid_en=0, idex_en=1, flush_idex=1; stall_count +1. With rt_ex=0 instead -> no stall.
- Store in MEM, dhit low for 3 cycles then high -> 3 cycles of all enables=0, pc_en=0, no flushes; stall_count=3; fourth cycle all enables=1.
- redirect_mem=1 with lu=1 and ihit=0 simultaneously -> all enables=1, three flushes=1, pc_en=1; flush_count=1, stall_count unchanged.
- ihit=0 for 2 cycles, nothing else -> flush_ifid=1, ifid_en=1, pc_en=0 each cycle; stall_count=2.
- Halt sequence:
  - halt_mem=1 with dhit pending on a load in MEM: stays RUN with all enables 0.
  - After dhit: one DRAIN cycle with memwb_en=1 only.
  - Then halted=1 with all outputs 0 for 10+ cycles.
  - RST -> RUN, counters 0.
- Preload stall_count to all-ones via forced stalls (CNT_W=4, 20 stall cycles) -> saturates at 15, no wrap.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline controller FSM state and register index.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detect: a load in EX writes a register the ID instruction reads.
module hazard_unit
  import cpu_types_pkg::*;
(
  input  logic     memren_ex,
  input  regbits_t rt_ex,
  input  regbits_t rs_id,
  input  regbits_t rt_id,
  input  logic     uses_rt_id,
  output logic     lu
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu = memren_ex && (rt_ex != '0) &&
              ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: stage enables/flushes, PC enable, halt drain FSM, perf counters.
module pipeline_controller
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemren_mem,
  input  logic             dmemwen_mem,
  input  logic             memren_ex,
  input  regbits_t         rt_ex,
  input  regbits_t         rs_id,
  input  regbits_t         rt_id,
  input  logic             uses_rt_id,
  input  logic             redirect_mem,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_state_t state;
  logic        lu;
  logic        dstall;

  hazard_unit u_hazard (
    .memren_ex  (memren_ex),
    .rt_ex      (rt_ex),
    .rs_id      (rs_id),
    .rt_id      (rt_id),
    .uses_rt_id (uses_rt_id),
    .lu         (lu)
  );

  assign dstall = (dmemren_mem || dmemwen_mem) && !dhit;

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    unique case (state)
      RUN: begin
        if (dstall) begin
          // whole pipe holds while the MEM access retries
        end else if (halt_mem) begin
          {ifid_en, idex_en, exmem_en, memwb_en}  = 4'b1111;
          {flush_ifid, flush_idex, flush_exmem}   = 3'b111;
        end else if (redirect_mem) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          {flush_ifid, flush_idex, flush_exmem}         = 3'b111;
        end else if (lu) begin
          {idex_en, exmem_en, memwb_en} = 3'b111;
          flush_idex                    = 1'b1;
        end else if (!ihit) begin
          {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
          flush_ifid                             = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
      end
      DRAIN:   memwb_en = 1'b1;
      HALTED:  ;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      halted      <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!pc_en && !(&stall_count))
            stall_count <= stall_count + 1'b1;
          if (redirect_mem && !dstall && !(&flush_count))
            flush_count <= flush_count + 1'b1;
          if (halt_mem && !dstall)
            state <= DRAIN;
        end
        DRAIN: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  // halt and redirect resolving in the same MEM slot cannot come from a legal program
  a_no_halt_redirect: assert property (@(posedge CLK) disable iff (RST)
    !(halt_mem && redirect_mem));

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomized + directed bench for pipeline_controller against a rule-level reference model.
module tb_pipeline_controller;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dhit, dmemren_mem, dmemwen_mem, memren_ex;
  logic [4:0]       rt_ex, rs_id, rt_id;
  logic             uses_rt_id, redirect_mem, halt_mem;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             flush_ifid, flush_idex, flush_exmem, halted;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipeline_controller #(.CNT_W(CNT_W)) u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dmemren_mem(dmemren_mem), .dmemwen_mem(dmemwen_mem),
    .memren_ex(memren_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rt_id(uses_rt_id), .redirect_mem(redirect_mem), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int m_state;   // 0 running, 1 draining, 2 halted
  int m_stall, m_flush;
  bit m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush_ifid, flush_idex, flush_exmem}
  function automatic logic [7:0] exp_out();
    bit ds, lu;
    ds = (dmemren_mem || dmemwen_mem) && !dhit;
    lu = memren_ex && rt_ex != 0 && (rt_ex == rs_id || (uses_rt_id && rt_ex == rt_id));
    if (m_state == 2) return 8'b0000_0000;
    if (m_state == 1) return 8'b0000_1000;
    if (ds)           return 8'b0000_0000;
    if (halt_mem)     return 8'b0111_1111;
    if (redirect_mem) return 8'b1111_1111;
    if (lu)           return 8'b0011_1010;
    if (!ihit)        return 8'b0111_1100;
    return 8'b1111_1000;
  endfunction

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic step();
    logic [7:0] e;
    bit ds;
    #3;
    e  = exp_out();
    ds = (dmemren_mem || dmemwen_mem) && !dhit;
    chk("ctrl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush_ifid, flush_idex, flush_exmem}, e);
    chk("halted", halted, m_halted);
    chk("stall_count", stall_count, m_stall);
    chk("flush_count", flush_count, m_flush);
    @(posedge CLK);
    if (RST) begin
      m_state = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    end else if (m_state == 0) begin
      if (!e[7] && m_stall < CMAX) m_stall++;
      if (redirect_mem && !ds && m_flush < CMAX) m_flush++;
      if (halt_mem && !ds) m_state = 1;
    end else if (m_state == 1) begin
      m_state = 2; m_halted = 1;
    end
    #1;
  endtask

  task automatic idle();
    RST = 0; ihit = 1; dhit = 1; dmemren_mem = 0; dmemwen_mem = 0; memren_ex = 0;
    rt_ex = 0; rs_id = 0; rt_id = 0; uses_rt_id = 0; redirect_mem = 0; halt_mem = 0;
  endtask

  task automatic do_reset();
    idle(); RST = 1; step(); RST = 0;
  endtask

  initial begin
    idle(); RST = 1;
    @(posedge CLK); #1;
    m_state = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    step();                                     // reset state, held in reset
    RST = 0;

    // load-use on rs
    do_reset();
    memren_ex = 1; rt_ex = 5; rs_id = 5; step();
    chk("lu_stall", stall_count, 1);
    rt_ex = 0; rs_id = 0; step();               // r0 target: no stall
    chk("lu_r0", pc_en, 1);

    // store waiting on dhit for three cycles
    do_reset(); dmemwen_mem = 1; dhit = 0;
    repeat (3) step();
    chk("dstall_cnt", stall_count, 3);
    dhit = 1; step();
    chk("dstall_release", {ifid_en, idex_en, exmem_en, memwb_en}, 4'hF);

    // redirect beats lu and !ihit together
    do_reset(); redirect_mem = 1; memren_ex = 1; rt_ex = 7; rt_id = 7; uses_rt_id = 1; ihit = 0;
    step(); idle(); step();
    chk("redir_flush", flush_count, 1);
    chk("redir_stall", stall_count, 0);

    // icache miss for two cycles
    do_reset(); ihit = 0; repeat (2) step(); idle(); step();
    chk("imiss_stall", stall_count, 2);

    // halt behind a pending load, drain, sticky halt, reset
    do_reset(); dmemren_mem = 1; dhit = 0; halt_mem = 1;
    repeat (2) step();
    dhit = 1; step();
    idle(); step();                             // drain
    repeat (12) step();
    chk("halt_sticky", halted, 1);
    chk("halt_pc", pc_en, 0);
    do_reset(); step();
    chk("halt_reset", {halted, stall_count, flush_count}, 0);

    // saturation
    do_reset(); ihit = 0; repeat (20) step(); idle(); step();
    chk("stall_sat", stall_count, CMAX);

    // random segments, occasional reset including mid-stall / mid-drain
    for (int s = 0; s < 40; s++) begin
      do_reset();
      for (int c = 0; c < 16; c++) begin
        RST          = ($urandom_range(0, 29) == 0);
        ihit         = ($urandom_range(0, 3) != 0);
        dhit         = ($urandom_range(0, 3) != 0);
        dmemren_mem  = ($urandom_range(0, 3) == 0);
        dmemwen_mem  = !dmemren_mem && ($urandom_range(0, 5) == 0);
        memren_ex    = ($urandom_range(0, 2) == 0);
        rt_ex        = 5'($urandom_range(0, 3));
        rs_id        = 5'($urandom_range(0, 3));
        rt_id        = 5'($urandom_range(0, 3));
        uses_rt_id   = $urandom_range(0, 1) == 1;
        halt_mem     = ($urandom_range(0, 14) == 0);
        redirect_mem = !halt_mem && ($urandom_range(0, 5) == 0);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
